// File: rtl/kfps2kb_cmd_pkg.sv
// Shared types and protocol constants for the PS/2 keyboard command scheduler.
`timescale 1ns/1ps
package kfps2kb_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND_CMD = 3'd1,
        ST_WAIT_CMD = 3'd2,
        ST_SEND_ARG = 3'd3,
        ST_WAIT_ARG = 3'd4,
        ST_WAIT_BAT = 3'd5
    } state_t;

    // Host-to-keyboard command bytes
    localparam logic [7:0] CMD_RESET     = 8'hFF;
    localparam logic [7:0] CMD_LEDS      = 8'hED;
    localparam logic [7:0] CMD_TYPEMATIC = 8'hF3;

    // Keyboard-to-host response bytes
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;

    // Bit positions inside the pending / grant vectors
    localparam int GNT_RESET     = 0;
    localparam int GNT_LEDS      = 1;
    localparam int GNT_TYPEMATIC = 2;
    localparam int NUM_CMDS      = 3;

    // Fixed priority: reset > leds > typematic
    function automatic logic [2:0] pick_grant(input logic [2:0] pending);
        logic [2:0] gnt;
        gnt = 3'b000;
        if (pending[GNT_RESET])          gnt = 3'b001;
        else if (pending[GNT_LEDS])      gnt = 3'b010;
        else if (pending[GNT_TYPEMATIC]) gnt = 3'b100;
        return gnt;
    endfunction

    // Command byte that opens the sequence for a one-hot grant
    function automatic logic [7:0] cmd_byte(input logic [2:0] gnt);
        logic [7:0] b;
        b = CMD_RESET;
        if (gnt[GNT_LEDS])           b = CMD_LEDS;
        else if (gnt[GNT_TYPEMATIC]) b = CMD_TYPEMATIC;
        return b;
    endfunction

endpackage

// File: rtl/kfps2kb_cmd_timer.sv
// Clearable free-running counter used to time device responses.
`timescale 1ns/1ps
module kfps2kb_cmd_timer #(
    parameter int WIDTH = 24
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Clear wins over enable so every state change restarts the count at zero
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/kfps2kb_command_scheduler.sv
// Arbitrates reset / LED / typematic requests and runs each PS/2 command
// exchange (command byte, optional argument, ACK/resend/BAT handling).
`timescale 1ns/1ps
module kfps2kb_command_scheduler
    import kfps2kb_cmd_pkg::*;
#(
    parameter logic [15:0] ack_timeout = 16'd20000,
    parameter logic [23:0] bat_timeout = 24'd2000000,
    parameter logic [1:0]  max_retries = 2'd3
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       req_reset,
    input  logic       req_leds,
    input  logic       req_typematic,
    input  logic [2:0] led_value,
    input  logic [7:0] typematic_value,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       kb_valid,
    output logic [7:0] kb_data,
    output logic       busy,
    output logic [2:0] grant,
    output logic       done,
    output logic       error
);

    localparam logic [23:0] ACK_LAST = {8'd0, ack_timeout} - 24'd1;
    localparam logic [23:0] BAT_LAST = bat_timeout - 24'd1;

    state_t      r_state, w_state_next;
    logic [2:0]  r_pending, w_pending_next, w_pending_clr, w_req;
    logic [2:0]  r_grant, w_grant_next, w_pick;
    logic [7:0]  r_arg, w_arg_next;
    logic [7:0]  r_tx_data, w_tx_data_next;
    logic [1:0]  r_retry, w_retry_next;
    logic        r_done, w_done;
    logic        r_error, w_error;
    logic        r_kb_valid;
    logic [7:0]  r_kb_data;
    logic [23:0] w_count;
    logic        w_timer_clear, w_timer_en;
    logic        w_rx_ack, w_rx_resend, w_rx_bat_ok, w_rx_bat_fail;
    logic        w_ack_expired, w_bat_expired;

    assign w_req = {req_typematic, req_leds, req_reset};

    // A new request sets its bit even in the cycle the same command retires
    generate
        for (genvar gi = 0; gi < NUM_CMDS; gi++) begin : g_pending
            assign w_pending_next[gi] = (r_pending[gi] & ~w_pending_clr[gi]) | w_req[gi];
        end
    endgenerate

    assign w_pick        = pick_grant(r_pending);
    assign w_rx_ack      = rx_valid && (rx_data == RSP_ACK);
    assign w_rx_resend   = rx_valid && (rx_data == RSP_RESEND);
    assign w_rx_bat_ok   = rx_valid && (rx_data == RSP_BAT_OK);
    assign w_rx_bat_fail = rx_valid && (rx_data == RSP_BAT_FAIL);
    assign w_ack_expired = (w_count == ACK_LAST);
    assign w_bat_expired = (w_count == BAT_LAST);

    // Counter only runs while waiting on the device and restarts on any transition
    assign w_timer_en    = (r_state == ST_WAIT_CMD) || (r_state == ST_WAIT_ARG) ||
                           (r_state == ST_WAIT_BAT);
    assign w_timer_clear = (w_state_next != r_state);

    kfps2kb_cmd_timer #(.WIDTH(24)) u_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .i_clear  (w_timer_clear),
        .i_enable (w_timer_en),
        .o_count  (w_count)
    );

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    // Next-state logic and the datapath updates that go with each transition
    always_comb begin
        w_state_next   = r_state;
        w_grant_next   = r_grant;
        w_arg_next     = r_arg;
        w_tx_data_next = r_tx_data;
        w_retry_next   = r_retry;
        w_pending_clr  = 3'b000;
        w_done         = 1'b0;
        w_error        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_retry_next = '0;
                if (|r_pending) begin
                    w_grant_next   = w_pick;
                    w_tx_data_next = cmd_byte(w_pick);
                    w_arg_next     = 8'h00;
                    if (w_pick[GNT_LEDS])           w_arg_next = {5'b0, led_value};
                    else if (w_pick[GNT_TYPEMATIC]) w_arg_next = typematic_value;
                    w_state_next   = ST_SEND_CMD;
                end
            end
            ST_SEND_CMD: if (tx_ready) w_state_next = ST_WAIT_CMD;
            ST_SEND_ARG: if (tx_ready) w_state_next = ST_WAIT_ARG;
            ST_WAIT_CMD, ST_WAIT_ARG: begin
                if (w_rx_ack) begin
                    w_retry_next = '0;
                    if (r_state == ST_WAIT_ARG) begin
                        w_done        = 1'b1;
                        w_pending_clr = r_grant;
                        w_grant_next  = '0;
                        w_state_next  = ST_IDLE;
                    end else if (r_grant[GNT_RESET]) begin
                        w_state_next = ST_WAIT_BAT;
                    end else begin
                        w_tx_data_next = r_arg;
                        w_state_next   = ST_SEND_ARG;
                    end
                end else if (w_rx_resend || w_ack_expired) begin
                    if (r_retry == max_retries) begin
                        w_error       = 1'b1;
                        w_pending_clr = r_grant;
                        w_grant_next  = '0;
                        w_state_next  = ST_IDLE;
                    end else begin
                        w_retry_next = r_retry + 2'd1;
                        w_state_next = (r_state == ST_WAIT_CMD) ? ST_SEND_CMD : ST_SEND_ARG;
                    end
                end
            end
            ST_WAIT_BAT: begin
                if (w_rx_bat_ok) begin
                    w_done        = 1'b1;
                    w_pending_clr = r_grant;
                    w_grant_next  = '0;
                    w_state_next  = ST_IDLE;
                end else if (w_rx_bat_fail || w_bat_expired) begin
                    w_error       = 1'b1;
                    w_pending_clr = r_grant;
                    w_grant_next  = '0;
                    w_state_next  = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Datapath registers: pending bits, grant, argument, tx byte, retries, pulses
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= '0;
            r_grant   <= '0;
            r_arg     <= '0;
            r_tx_data <= '0;
            r_retry   <= '0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_pending <= w_pending_next;
            r_grant   <= w_grant_next;
            r_arg     <= w_arg_next;
            r_tx_data <= w_tx_data_next;
            r_retry   <= w_retry_next;
            r_done    <= w_done;
            r_error   <= w_error;
        end
    end

    // Scan bytes reach the keycode logic only while no command owns the link
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_kb_valid <= 1'b0;
            r_kb_data  <= '0;
        end else begin
            r_kb_valid <= rx_valid && (r_state == ST_IDLE);
            if (rx_valid && (r_state == ST_IDLE)) r_kb_data <= rx_data;
        end
    end

    assign tx_valid = (r_state == ST_SEND_CMD) || (r_state == ST_SEND_ARG);
    assign tx_data  = r_tx_data;
    assign busy     = (r_state != ST_IDLE);
    assign grant    = r_grant;
    assign done     = r_done;
    assign error    = r_error;
    assign kb_valid = r_kb_valid;
    assign kb_data  = r_kb_data;

endmodule

// File: tb/tb_kfps2kb_command_scheduler.sv
// Scoreboard bench for the PS/2 command scheduler.
`timescale 1ns/1ps
module tb_kfps2kb_command_scheduler;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       req_reset, req_leds, req_typematic;
    logic [2:0] led_value;
    logic [7:0] typematic_value;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       kb_valid;
    logic [7:0] kb_data;
    logic       busy;
    logic [2:0] grant;
    logic       done, error;

    kfps2kb_command_scheduler #(
        .ack_timeout (16'd16),
        .bat_timeout (24'd64),
        .max_retries (2'd3)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .req_reset       (req_reset),
        .req_leds        (req_leds),
        .req_typematic   (req_typematic),
        .led_value       (led_value),
        .typematic_value (typematic_value),
        .tx_valid        (tx_valid),
        .tx_data         (tx_data),
        .tx_ready        (tx_ready),
        .rx_valid        (rx_valid),
        .rx_data         (rx_data),
        .kb_valid        (kb_valid),
        .kb_data         (kb_data),
        .busy            (busy),
        .grant           (grant),
        .done            (done),
        .error           (error)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] gnt;
    } tx_exp_t;

    tx_exp_t    txq[$];
    int         evq[$];   // 1 = done, 2 = error
    logic [7:0] kbq[$];

    int n_tests = 0;
    int n_fail  = 0;
    int n_hs    = 0;
    int n_evt   = 0;
    int hs_target = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: pops expectations whenever the DUT produces a transaction
    always @(negedge clock) begin
        if (reset_n) begin
            if (tx_valid && tx_ready) begin
                n_hs++;
                $display("[TB] tx byte %02h grant %03b", tx_data, grant);
                if (txq.size() == 0) begin
                    check("tx_q", txq.size(), 1);
                end else begin
                    tx_exp_t e;
                    e = txq.pop_front();
                    check("tx_data", tx_data, e.data);
                    check("grant", grant, e.gnt);
                end
            end
            if (done || error) begin
                n_evt++;
                $display("[TB] event done=%0b error=%0b", done, error);
                if (evq.size() == 0) check("ev_q", evq.size(), 1);
                else                 check("event", {error, done}, evq.pop_front());
            end
            if (kb_valid) begin
                $display("[TB] kb byte %02h", kb_data);
                if (kbq.size() == 0) check("kb_q", kbq.size(), 1);
                else                 check("kb_data", kb_data, kbq.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_tx(input logic [7:0] d, input logic [2:0] g);
        tx_exp_t e;
        e.data = d;
        e.gnt  = g;
        txq.push_back(e);
    endtask

    task automatic pulse_req(input logic [2:0] m);
        req_reset     = m[0];
        req_leds      = m[1];
        req_typematic = m[2];
        tick();
        req_reset     = 1'b0;
        req_leds      = 1'b0;
        req_typematic = 1'b0;
    endtask

    task automatic pulse_rx(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic wait_hs();
        hs_target++;
        for (int i = 0; i < 100 && n_hs < hs_target; i++) tick();
        check("hs_count", n_hs, hs_target);
    endtask

    task automatic wait_ev();
        for (int i = 0; i < 300 && evq.size() != 0; i++) tick();
        check("ev_drain", evq.size(), 0);
    endtask

    // Cycles spent waiting on the device before a resend or retirement
    task automatic measure_wait(output int n);
        n = 0;
        for (int i = 0; i < 300 && busy && !tx_valid; i++) begin
            n++;
            tick();
        end
    endtask

    int wl;
    int saved_evt;

    initial begin
        reset_n = 1'b0;
        req_reset = 1'b0; req_leds = 1'b0; req_typematic = 1'b0;
        led_value = 3'b000; typematic_value = 8'h00;
        tx_ready = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) tick();
        check("rst_tx_valid", tx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);
        check("rst_done_err", {done, error}, 0);
        check("rst_kb", {kb_valid, kb_data}, 0);
        check("rst_tx_data", tx_data, 0);
        reset_n = 1'b1;
        repeat (2) tick();

        // Idle pass-through of scan bytes
        kbq.push_back(8'h1C);
        pulse_rx(8'h1C);
        check("kb_lat", kb_valid, 1);
        tick();

        // LED command with argument captured at grant
        led_value = 3'b101;
        push_tx(8'hED, 3'b010);
        push_tx(8'h05, 3'b010);
        evq.push_back(1);
        pulse_req(3'b010);
        tick();
        led_value = 3'b010;
        check("leds_busy", busy, 1);
        check("leds_grant", grant, 3'b010);
        wait_hs(); pulse_rx(8'hFA);
        wait_hs(); pulse_rx(8'hFA);
        wait_ev();
        repeat (4) tick();
        check("leds_idle", busy, 0);

        // Reset command, BAT passes
        push_tx(8'hFF, 3'b001);
        evq.push_back(1);
        pulse_req(3'b001);
        wait_hs(); pulse_rx(8'hFA);
        repeat (5) tick();
        check("bat_busy", busy, 1);
        check("bat_no_tx", tx_valid, 0);
        pulse_rx(8'hAA);
        wait_ev();

        // Reset command, BAT fails; pending must not re-grant
        push_tx(8'hFF, 3'b001);
        evq.push_back(2);
        pulse_req(3'b001);
        wait_hs(); pulse_rx(8'hFA);
        pulse_rx(8'hFC);
        wait_ev();
        repeat (4) tick();
        check("batfail_idle", busy, 0);

        // Typematic with three resends then success
        typematic_value = 8'h2B;
        for (int i = 0; i < 4; i++) push_tx(8'hF3, 3'b100);
        push_tx(8'h2B, 3'b100);
        evq.push_back(1);
        pulse_req(3'b100);
        for (int i = 0; i < 3; i++) begin
            wait_hs(); pulse_rx(8'hFE);
        end
        wait_hs(); pulse_rx(8'hFA);
        wait_hs(); pulse_rx(8'hFA);
        wait_ev();

        // Typematic with four resends -> error
        for (int i = 0; i < 4; i++) push_tx(8'hF3, 3'b100);
        evq.push_back(2);
        pulse_req(3'b100);
        for (int i = 0; i < 4; i++) begin
            wait_hs(); pulse_rx(8'hFE);
        end
        wait_ev();
        repeat (4) tick();
        check("retry_idle", busy, 0);

        // Simultaneous leds + typematic, back-pressure, ignored bytes
        tx_ready = 1'b0;
        led_value = 3'b011;
        typematic_value = 8'h44;
        push_tx(8'hED, 3'b010);
        push_tx(8'h03, 3'b010);
        push_tx(8'hF3, 3'b100);
        push_tx(8'h44, 3'b100);
        evq.push_back(1);
        evq.push_back(1);
        pulse_req(3'b110);
        repeat (5) tick();
        check("hold_valid", tx_valid, 1);
        check("hold_data", tx_data, 8'hED);
        tx_ready = 1'b1;
        pulse_rx(8'hFA);          // lands in the handshake cycle
        wait_hs();
        pulse_rx(8'h1C);          // unrelated byte while waiting
        check("wait_no_kb", kb_valid, 0);
        check("wait_stay", tx_valid, 0);
        pulse_rx(8'hFA);
        wait_hs(); pulse_rx(8'hFA);
        wait_hs(); pulse_rx(8'hFA);
        wait_hs(); pulse_rx(8'hFA);
        wait_ev();

        // Silent device: timeouts drive resends then an error
        led_value = 3'b001;
        for (int i = 0; i < 4; i++) push_tx(8'hED, 3'b010);
        evq.push_back(2);
        pulse_req(3'b010);
        for (int i = 0; i < 4; i++) begin
            wait_hs();
            measure_wait(wl);
            check("ack_wait_len", wl, 16);
        end
        wait_ev();

        // BAT timeout
        push_tx(8'hFF, 3'b001);
        evq.push_back(2);
        pulse_req(3'b001);
        wait_hs(); pulse_rx(8'hFA);
        measure_wait(wl);
        check("bat_wait_len", wl, 64);
        wait_ev();

        // Reset pulse while waiting for an ACK
        push_tx(8'hF3, 3'b100);
        pulse_req(3'b100);
        wait_hs();
        repeat (3) tick();
        reset_n = 1'b0;
        #2;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_grant", grant, 0);
        check("mid_rst_tx", {tx_valid, tx_data}, 0);
        check("mid_rst_pulses", {done, error, kb_valid}, 0);
        tick();
        reset_n = 1'b1;
        saved_evt = n_evt;
        repeat (40) tick();
        check("post_rst_evt", n_evt, saved_evt);
        check("post_rst_busy", busy, 0);
        check("txq_left", txq.size(), 0);
        check("kbq_left", kbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
